// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: one main register driving the output plus a
// one-word skid register, so in_ready_o can be registered without losing throughput.
// Also watches the upstream handshake and flags words withdrawn or altered before acceptance.
module pipe_stage_reg #(
    parameter int unsigned          DATA_W  = 64,
    parameter logic [DATA_W-1:0]    NOP_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o,
    output logic              err_o
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [DATA_W-1:0] shadow_q;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              push, pop;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i & ~stall_i;

    // State and storage registers; reset wins over flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StEmpty;
            main_q   <= NOP_VAL;
            skid_q   <= NOP_VAL;
            shadow_q <= NOP_VAL;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            shadow_q <= in_data_i;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath selection; flush squashes both held words and this cycle's input.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d = StOne;
                        main_d  = in_data_i;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_d = in_data_i;
                    end else if (push) begin
                        state_d = StTwo;
                        skid_d  = in_data_i;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Protocol monitor: an offer refused last cycle must be repeated unchanged this cycle.
    always_comb begin
        pend_d = in_valid_i & ~in_ready_o & ~flush_i;
        err_d  = err_q;
        if (pend_q && (!in_valid_i || (in_data_i != shadow_q))) begin
            err_d = 1'b1;
        end
    end

    // Outputs decoded purely from registered state, so in_ready has no path from out_ready.
    always_comb begin
        out_valid_o = 1'b0;
        in_ready_o  = 1'b1;
        occ_o       = 2'd0;
        unique case (state_q)
            StEmpty: begin
                out_valid_o = 1'b0;
                in_ready_o  = 1'b1;
                occ_o       = 2'd0;
            end
            StOne: begin
                out_valid_o = 1'b1;
                in_ready_o  = 1'b1;
                occ_o       = 2'd1;
            end
            StTwo: begin
                out_valid_o = 1'b1;
                in_ready_o  = 1'b0;
                occ_o       = 2'd2;
            end
            default: begin
                out_valid_o = 1'b0;
                in_ready_o  = 1'b1;
                occ_o       = 2'd0;
            end
        endcase
        out_data_o = out_valid_o ? main_q : NOP_VAL;
        err_o      = err_q;
    end

endmodule
